// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the dmem req/ready interface.
// Fixed-latency word reads/writes from an on-chip array, with error responses and access counters.
module dmem_responder #(
  parameter int unsigned       DWidth   = 32,
  parameter int unsigned       Depth    = 1024,
  parameter logic [DWidth-1:0] BaseAddr = 32'h00004000,
  parameter int unsigned       Latency  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              err_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int unsigned AW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(Latency - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, next_state_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic [DWidth-1:0] addr_r, wdata_r;
  logic              write_r;
  logic              ready_r, err_r;
  logic [DWidth-1:0] rdata_r;
  logic [31:0]       rd_cnt_r, wr_cnt_r;
  logic [DWidth-1:0] mem_r [Depth];

  logic              accept_s, enter_resp_s, write_en_s;
  logic [DWidth-1:0] acc_addr_s, off_s, word_s;
  logic              acc_write_s, acc_err_s;
  logic [AW-1:0]     acc_idx_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Next-state and latency down-counter
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          accept_s     = 1'b1;
          cnt_next_s   = LAT_M1;
          next_state_s = (LAT_M1 == 4'd0) ? RESP : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  assign enter_resp_s = (next_state_s == RESP);

  // Access source: live inputs in IDLE (a Latency of 1 responds straight from accept), else latched
  always_comb begin
    if (state_r == IDLE) begin
      acc_addr_s  = addr_i;
      acc_write_s = write_i;
    end else begin
      acc_addr_s  = addr_r;
      acc_write_s = write_r;
    end
  end

  assign off_s      = acc_addr_s - BaseAddr;
  assign word_s     = off_s >> 2;
  assign acc_err_s  = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s < BaseAddr) ||
                      (word_s >= DWidth'(Depth));
  assign acc_idx_s  = word_s[AW-1:0];

  // A write commits only at the RESP edge, so a reset on that edge drops it
  assign write_en_s = (state_r == RESP) && write_r && !err_r && !rst_i;

  // State, access latches, response and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= {DWidth{1'b0}};
      wdata_r  <= {DWidth{1'b0}};
      write_r  <= 1'b0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= {DWidth{1'b0}};
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      ready_r <= enter_resp_s;
      if (accept_s) begin
        addr_r  <= addr_i;
        write_r <= write_i;
        wdata_r <= wdata_i;
      end
      if (enter_resp_s) begin
        err_r   <= acc_err_s;
        rdata_r <= (acc_err_s || acc_write_s) ? {DWidth{1'b0}} : mem_r[acc_idx_s];
      end
      if ((state_r == RESP) && !err_r) begin
        if (write_r) begin
          wr_cnt_r <= sat_inc(wr_cnt_r);
        end else begin
          rd_cnt_r <= sat_inc(rd_cnt_r);
        end
      end
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (write_en_s) begin
      mem_r[acc_idx_s] <= wdata_r;
    end
  end

  assign ready_o  = ready_r;
  assign rdata_o  = rdata_r;
  assign err_o    = err_r;
  assign rd_cnt_o = rd_cnt_r;
  assign wr_cnt_o = wr_cnt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven accesses with a response scoreboard on a Latency=2
// instance, plus hand sequences for held requests, reset abort, WAIT-time input changes and Latency=1.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, wr, ready, err;
  logic [31:0] addr, wdata, rdata, rdc, wrc;
  logic        req_1, wr_1, ready_1, err_1;
  logic [31:0] addr_1, wdata_1, rdata_1, rdc_1, wrc_1;

  dmem_responder #(.DWidth(32), .Depth(1024), .BaseAddr(32'h0000_4000), .Latency(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .rdata_o(rdata), .err_o(err), .rd_cnt_o(rdc), .wr_cnt_o(wrc)
  );

  dmem_responder #(.DWidth(32), .Depth(1024), .BaseAddr(32'h0000_4000), .Latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_1), .write_i(wr_1), .addr_i(addr_1), .wdata_i(wdata_1),
    .ready_o(ready_1), .rdata_o(rdata_1), .err_o(err_1), .rd_cnt_o(rdc_1), .wr_cnt_o(wrc_1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int exp_rd     = 0;
  int exp_wr     = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          edge_n;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vt[12];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, want, cyc);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expected response, on its edge
  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ready: got ready at edge %0d, required none", cyc + 1);
      end else begin
        e = exp_q.pop_front();
        check32("resp_edge", 32'(cyc + 1), 32'(e.edge_n));
        check32("resp_err", 32'(err), 32'(e.err));
        check32("resp_rdata", rdata, e.rdata);
      end
    end else if ((exp_q.size() != 0) && (exp_q[0].edge_n <= cyc + 1)) begin
      compared++;
      mismatched++;
      $display("FAIL missing_ready: got none at edge %0d, required at edge %0d",
               cyc + 1, exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
  end

  // One access on the Latency=2 instance; called and returns just after a falling edge
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] alt, input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    e.err    = e_err;
    e.rdata  = e_rd;
    e.edge_n = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    req   = 1'b0;
    wr    = ~w;
    addr  = alt;
    wdata = ~d;
    repeat (LAT) @(negedge clk);
    if (!e_err) begin
      if (w) exp_wr++;
      else   exp_rd++;
    end
    check32("rd_cnt", rdc, 32'(exp_rd));
    check32("wr_cnt", wrc, 32'(exp_wr));
  endtask

  // One access on the Latency=1 instance, checking the strobe on the very next edge
  task automatic do_access_1(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic e_err, input logic [31:0] e_rd);
    req_1   = 1'b1;
    wr_1    = w;
    addr_1  = a;
    wdata_1 = d;
    @(negedge clk);
    req_1   = 1'b0;
    wr_1    = ~w;
    addr_1  = 32'h0000_4000;
    check32("l1_ready_at_t1", 32'(ready_1), 32'd1);
    check32("l1_err", 32'(err_1), 32'(e_err));
    check32("l1_rdata", rdata_1, e_rd);
    @(negedge clk);
    check32("l1_ready_one_cycle", 32'(ready_1), 32'd0);
  endtask

  initial begin
    int t0;
    vt[0]  = '{1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_3FFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vt[3]  = '{1'b0, 32'h0000_5000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vt[4]  = '{1'b1, 32'h0000_4002, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
    vt[5]  = '{1'b0, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vt[6]  = '{1'b1, 32'h0000_4FFC, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vt[7]  = '{1'b0, 32'h0000_4FFC, 32'h0000_0000, 1'b0, 32'h1234_5678};
    vt[8]  = '{1'b0, 32'h0000_4001, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vt[9]  = '{1'b1, 32'h0000_0000, 32'h7777_7777, 1'b1, 32'h0000_0000};
    vt[10] = '{1'b1, 32'h0000_4008, 32'h55AA_55AA, 1'b0, 32'h0000_0000};
    vt[11] = '{1'b0, 32'h0000_4008, 32'h0000_0000, 1'b0, 32'h55AA_55AA};

    rst = 1'b1;
    req = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    req_1 = 1'b0; wr_1 = 1'b0; addr_1 = 32'h0; wdata_1 = 32'h0;
    repeat (3) @(negedge clk);
    check32("rst_ready", 32'(ready), 32'd0);
    check32("rst_err", 32'(err), 32'd0);
    check32("rst_rdata", rdata, 32'h0);
    check32("rst_rd_cnt", rdc, 32'h0);
    check32("rst_wr_cnt", wrc, 32'h0);
    check32("rst_l1_ready", 32'(ready_1), 32'd0);
    check32("rst_l1_wr_cnt", wrc_1, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single accesses, including all error classes and the last legal word
    for (int i = 0; i < 12; i++) begin
      do_access(vt[i].w, vt[i].a, vt[i].d, vt[i].a ^ 32'h0000_0008, vt[i].e_err, vt[i].e_rd);
    end

    // Request held for 9 edges: accepts at T, T+3, T+6 -> ready at T+2, T+5, T+8
    t0 = cyc + 1;
    req = 1'b1; wr = 1'b0; addr = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.err = 1'b0; e.rdata = 32'hDEAD_BEEF; e.edge_n = t0 + 2 + 3 * k;
      exp_q.push_back(e);
    end
    repeat (9) @(negedge clk);
    req = 1'b0;
    exp_rd += 3;
    @(negedge clk);
    check32("held_rd_cnt", rdc, 32'(exp_rd));

    // Reset one cycle after accepting a write aborts it without a response
    do_access(1'b1, 32'h0000_4004, 32'h1111_1111, 32'h0000_4010, 1'b0, 32'h0);
    req = 1'b1; wr = 1'b1; addr = 32'h0000_4004; wdata = 32'h2222_2222;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (3) @(negedge clk);
    check32("abort_rd_cnt", rdc, 32'h0);
    check32("abort_wr_cnt", wrc, 32'h0);
    check32("abort_err", 32'(err), 32'd0);
    do_access(1'b0, 32'h0000_4004, 32'h0, 32'h0000_4000, 1'b0, 32'h1111_1111);

    // Address moved during WAIT: response still comes from the latched word 0
    do_access(1'b0, 32'h0000_4000, 32'h0, 32'h0000_4008, 1'b0, 32'hDEAD_BEEF);

    // Latency=1 instance: write, read back, error, then saturation of the write counter
    do_access_1(1'b1, 32'h0000_4010, 32'hA5A5_A5A5, 1'b0, 32'h0);
    check32("l1_wr_cnt", wrc_1, 32'h1);
    do_access_1(1'b0, 32'h0000_4010, 32'h0, 1'b0, 32'hA5A5_A5A5);
    check32("l1_rd_cnt", rdc_1, 32'h1);
    do_access_1(1'b1, 32'h0000_4003, 32'h9999_9999, 1'b1, 32'h0);
    check32("l1_err_wr_cnt", wrc_1, 32'h1);
    force dut1.wr_cnt_r = 32'hFFFF_FFFF;
    do_access_1(1'b1, 32'h0000_4014, 32'h0000_0001, 1'b0, 32'h0);
    release dut1.wr_cnt_r;
    @(negedge clk);
    do_access_1(1'b1, 32'h0000_4014, 32'h0000_0002, 1'b0, 32'h0);
    check32("l1_wr_cnt_saturated", wrc_1, 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
